// File: rtl/perceptron_pkg.sv
// Shared sizing, frame constants, loader state encoding and flat-bus slicing
// helpers for the perceptron network and its weight loader.
package perceptron_pkg;

    localparam int N_NEURONS = 8;
    localparam int N_INPUTS  = 8;
    localparam int W         = 8;
    localparam int N_SLOTS   = N_INPUTS + 1;
    localparam int NEURON_W  = $clog2(N_NEURONS);
    localparam int SLOT_W    = $clog2(N_SLOTS);

    localparam logic [W-1:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
    } loader_state_t;

    // LSB of weight i of neuron n inside weights_flat.
    function automatic int weight_lsb(input int n, input int i);
        return (n * N_INPUTS + i) * W;
    endfunction

    function automatic int bias_lsb(input int n);
        return n * W;
    endfunction

endpackage

// File: rtl/perceptron_weight_loader_bank.sv
// Double-buffered parameter storage: shadow bank written byte by byte, active
// bank replaced from the shadow bank in a single cycle on commit.
module weight_bank
    import perceptron_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [NEURON_W-1:0]               wr_neuron,
    input  logic [SLOT_W-1:0]                 wr_slot,
    input  logic [W-1:0]                      wr_data,
    input  logic                              commit,
    output logic [N_NEURONS*N_INPUTS*W-1:0]   weights_flat,
    output logic [N_NEURONS*W-1:0]            bias_flat
);

    logic [W-1:0] shadow [N_NEURONS][N_SLOTS];
    logic [W-1:0] active [N_NEURONS][N_SLOTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                for (int s = 0; s < N_SLOTS; s++) begin
                    shadow[n][s] <= '0;
                    active[n][s] <= '0;
                end
            end
        end else begin
            if (we) begin
                shadow[wr_neuron][wr_slot] <= wr_data;
            end
            if (commit) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    for (int s = 0; s < N_SLOTS; s++) begin
                        active[n][s] <= shadow[n][s];
                    end
                end
            end
        end
    end

    // Slot N_INPUTS of each neuron holds its bias.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        for (genvar i = 0; i < N_INPUTS; i++) begin : g_input
            assign weights_flat[weight_lsb(n, i) +: W] = active[n][i];
        end
        assign bias_flat[bias_lsb(n) +: W] = active[n][N_INPUTS];
    end

endmodule

// File: rtl/perceptron_weight_loader.sv
// Receives SYNC-framed, XOR-checksummed weight/bias frames from a byte stream
// and atomically updates the parameters driving the perceptrons.
module perceptron_weight_loader
    import perceptron_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [W-1:0]                      in_data,
    input  logic                              abort,
    output logic [N_NEURONS*N_INPUTS*W-1:0]   weights_flat,
    output logic [N_NEURONS*W-1:0]            bias_flat,
    output logic                              weights_valid,
    output logic                              load_done,
    output logic                              load_err,
    output logic                              busy
);

    loader_state_t         state;
    logic [NEURON_W-1:0]   neuron;
    logic [SLOT_W-1:0]     slot;
    logic [W-1:0]          acc;
    logic                  xfer;
    logic                  bank_we;
    logic                  bank_commit;

    assign in_ready    = (state != COMMIT);
    // A byte presented together with abort is dropped, never consumed.
    assign xfer        = in_valid && in_ready && !abort;
    assign bank_we     = xfer && (state == LOAD);
    assign bank_commit = (state == COMMIT);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            neuron        <= '0;
            slot          <= '0;
            acc           <= '0;
            weights_valid <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (abort && state != COMMIT) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (xfer && in_data == SYNC) begin
                            state  <= LOAD;
                            neuron <= '0;
                            slot   <= '0;
                            acc    <= '0;
                        end
                    end
                    LOAD: begin
                        if (xfer) begin
                            acc <= acc ^ in_data;
                            if (slot == SLOT_W'(N_INPUTS)) begin
                                slot <= '0;
                                if (neuron == NEURON_W'(N_NEURONS - 1)) begin
                                    state <= CHECK;
                                end else begin
                                    neuron <= neuron + NEURON_W'(1);
                                end
                            end else begin
                                slot <= slot + SLOT_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (xfer) begin
                            if (in_data == acc) begin
                                state <= COMMIT;
                            end else begin
                                load_err <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                    end
                    COMMIT: begin
                        weights_valid <= 1'b1;
                        load_done     <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    weight_bank u_bank (
        .clk          (clk),
        .rst          (rst),
        .we           (bank_we),
        .wr_neuron    (neuron),
        .wr_slot      (slot),
        .wr_data      (in_data),
        .commit       (bank_commit),
        .weights_flat (weights_flat),
        .bias_flat    (bias_flat)
    );

endmodule

// File: tb/tb_perceptron_weight_loader.sv
// Directed bench for perceptron_weight_loader: good/bad frames, junk bytes,
// abort, gapped stream with SYNC-valued payload, and mid-frame reset.
module tb_perceptron_weight_loader;
    import perceptron_pkg::*;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             in_valid;
    logic                             in_ready;
    logic [W-1:0]                     in_data;
    logic                             abort;
    logic [N_NEURONS*N_INPUTS*W-1:0]  weights_flat;
    logic [N_NEURONS*W-1:0]           bias_flat;
    logic                             weights_valid;
    logic                             load_done;
    logic                             load_err;
    logic                             busy;

    int errors = 0;
    int checks = 0;
    int ready_stall = 0;

    logic [7:0]   pay [72];
    logic [511:0] exp_w;
    logic [63:0]  exp_b;
    logic [7:0]   wa [8];

    perceptron_weight_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .abort         (abort),
        .weights_flat  (weights_flat),
        .bias_flat     (bias_flat),
        .weights_valid (weights_valid),
        .load_done     (load_done),
        .load_err      (load_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        checks++;
        assert (!(load_done && load_err)) else begin
            errors++;
            $error("FAIL done_err_exclusive: observed done=%0b err=%0b, required not both high",
                   load_done, load_err);
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Called at a negedge; the byte transfers on the following posedge.
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            ready_stall++;
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", {511'b0, in_ready}, 512'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] calc_csum();
        logic [7:0] c = 8'h00;
        for (int k = 0; k < 72; k++) c = c ^ pay[k];
        return c;
    endfunction

    task automatic set_expected();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 8; i++) exp_w[(n*8+i)*8 +: 8] = pay[n*9+i];
            exp_b[n*8 +: 8] = pay[n*9+8];
        end
    endtask

    task automatic send_frame(input logic [7:0] flip, input bit gaps);
        send_byte(SYNC);
        for (int k = 0; k < 73; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
            if (k < 72) send_byte(pay[k]);
            else        send_byte(calc_csum() ^ flip);
        end
    endtask

    // Entered at the negedge right after the checksum edge (COMMIT cycle).
    task automatic expect_commit(input string tag);
        chk({tag, "_done_early"},   {511'b0, load_done}, 512'd0);
        chk({tag, "_ready_commit"}, {511'b0, in_ready},  512'd0);
        chk({tag, "_busy_commit"},  {511'b0, busy},      512'd1);
        @(negedge clk);
        chk({tag, "_done"},    {511'b0, load_done},     512'd1);
        chk({tag, "_err"},     {511'b0, load_err},      512'd0);
        chk({tag, "_valid"},   {511'b0, weights_valid}, 512'd1);
        chk({tag, "_weights"}, weights_flat,            exp_w);
        chk({tag, "_bias"},    {448'b0, bias_flat},     {448'b0, exp_b});
        chk({tag, "_idle"},    {511'b0, busy},          512'd0);
        chk({tag, "_ready"},   {511'b0, in_ready},      512'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {511'b0, load_done}, 512'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        abort    = 1'b0;
        wa = '{8'd2, 8'd4, 8'd2, 8'd1, 8'd5, 8'd2, 8'd2, 8'd2};
        repeat (3) @(negedge clk);
        chk("rst_weights", weights_flat, 512'd0);
        chk("rst_bias",    {448'b0, bias_flat}, 512'd0);
        chk("rst_valid",   {511'b0, weights_valid}, 512'd0);
        chk("rst_done",    {511'b0, load_done}, 512'd0);
        chk("rst_err",     {511'b0, load_err}, 512'd0);
        chk("rst_busy",    {511'b0, busy}, 512'd0);
        chk("rst_ready",   {511'b0, in_ready}, 512'd1);
        rst = 1'b0;
        @(negedge clk);

        // Frame A: same weights for every neuron, zero bias.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 8; i++) pay[n*9+i] = wa[i];
            pay[n*9+8] = 8'h00;
        end
        set_expected();
        send_frame(8'h00, 1'b0);
        expect_commit("A");
        chk("A_hand", weights_flat, {8{64'h0202_0205_0102_0402}});
        chk("A_w0",   {504'b0, weights_flat[7:0]},   512'd2);
        chk("A_w1",   {504'b0, weights_flat[15:8]},  512'd4);
        chk("A_w7",   {504'b0, weights_flat[63:56]}, 512'd2);

        // Same frame, corrupted checksum.
        send_frame(8'h01, 1'b0);
        chk("bad_err",   {511'b0, load_err}, 512'd1);
        chk("bad_done",  {511'b0, load_done}, 512'd0);
        chk("bad_busy",  {511'b0, busy}, 512'd0);
        @(negedge clk);
        chk("bad_err_pulse", {511'b0, load_err}, 512'd0);
        chk("bad_keep_w",    weights_flat, exp_w);
        chk("bad_keep_b",    {448'b0, bias_flat}, {448'b0, exp_b});
        chk("bad_keep_valid", {511'b0, weights_valid}, 512'd1);

        // Frame B preceded by junk bytes.
        for (int k = 0; k < 72; k++) pay[k] = 8'(k);
        set_expected();
        send_byte(8'h00);
        send_byte(8'h13);
        chk("junk_idle", {511'b0, busy}, 512'd0);
        send_frame(8'h00, 1'b0);
        expect_commit("B");
        chk("B_bias7",  {504'b0, bias_flat[63:56]},   512'h47);
        chk("B_n1_w0",  {504'b0, weights_flat[71:64]}, 512'd9);

        // Abort after 30 payload bytes of a different frame.
        for (int k = 0; k < 72; k++) pay[k] = 8'h5A;
        send_byte(SYNC);
        for (int k = 0; k < 30; k++) send_byte(pay[k]);
        in_valid = 1'b1;
        in_data  = 8'h33;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle", {511'b0, busy}, 512'd0);
        chk("abort_done", {511'b0, load_done}, 512'd0);
        chk("abort_err",  {511'b0, load_err}, 512'd0);
        chk("abort_keep_w", weights_flat, exp_w);
        idle(2);
        chk("abort_done2", {511'b0, load_done}, 512'd0);
        chk("abort_err2",  {511'b0, load_err}, 512'd0);
        for (int k = 0; k < 72; k++) pay[k] = 8'(8'hFF - k);
        set_expected();
        send_frame(8'h00, 1'b0);
        expect_commit("C");

        // Gapped stream with SYNC-valued payload bytes.
        ready_stall = 0;
        for (int k = 0; k < 72; k++) pay[k] = (k % 4 == 1) ? 8'hA5 : 8'(k * 7 + 3);
        set_expected();
        send_frame(8'h00, 1'b1);
        expect_commit("D");
        chk("D_no_stall", 512'(ready_stall), 512'd0);

        // Reset in the middle of a frame after a prior commit.
        send_byte(SYNC);
        for (int k = 0; k < 10; k++) send_byte(pay[k]);
        chk("mid_busy", {511'b0, busy}, 512'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_w",     weights_flat, 512'd0);
        chk("mid_rst_b",     {448'b0, bias_flat}, 512'd0);
        chk("mid_rst_valid", {511'b0, weights_valid}, 512'd0);
        chk("mid_rst_busy",  {511'b0, busy}, 512'd0);
        chk("mid_rst_ready", {511'b0, in_ready}, 512'd1);
        chk("mid_rst_done",  {511'b0, load_done}, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {511'b0, busy}, 512'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
